status_pack_tx: RTL and testbench

//  Return path of the fan control link. Periodically snapshots live fan status (mode, duty,

---
 rtl/status_pack_tx_if.sv | 13 +
 rtl/status_pack_tx.sv | 185 ++++++++++++++++++
 tb/tb_status_pack_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/status_pack_tx_if.sv
// Byte stream from the status packer to the UART transmitter.
//   tx_data  : byte currently offered
//   tx_valid : tx_data is valid
//   tx_ready : the transmitter accepts the byte (transfer on tx_valid & tx_ready)
// master = packer side, slave = UART side.
interface status_pack_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/status_pack_tx.sv
// status_pack_tx: return path of the fan control link. Snapshots fan status on a periodic
// tick or on report_req, packs it into a byte frame and streams it over a valid/ready link.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   mode               : 1 = manual, 0 = auto
//   duty_data[6:0]     : PWM duty in percent (clamped to 100 in the frame)
//   speed_data[11:0]   : fan speed in RPM
//   temp_data[7:0]     : temperature in degrees C
//   report_req         : single-cycle request for an immediate report
//   tx_if (master)     : tx_data / tx_valid out, tx_ready in
//   busy               : a frame is in progress (LOAD or SEND)
// Frame: HEAD, {mode,duty}, {4'b0,speed[11:8]}, speed[7:0], temp, [CHK], TAIL.
// Optional feature macro PACK_CHKSUM_EN: adds CHK = (byte1+byte2+byte3+byte4) mod 256.
module status_pack_tx #(
   parameter int unsigned PERIOD_CYC = 5_000_000,
   parameter logic [7:0]  HEAD_BYTE  = 8'hAA,
   parameter logic [7:0]  TAIL_BYTE  = 8'h55
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              mode,
   input  logic [6:0]        duty_data,
   input  logic [11:0]       speed_data,
   input  logic [7:0]        temp_data,
   input  logic              report_req,
   status_pack_tx_if.master  tx_if,
   output logic              busy
);

   localparam int unsigned TMR_W = $clog2(PERIOD_CYC);
   localparam int unsigned IDX_W = 3;
`ifdef PACK_CHKSUM_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);
`else
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               busy_q, busy_d;
   logic [7:0]         b1_q, b1_d;       // {mode, clamped duty}
   logic [3:0]         spd_hi_q, spd_hi_d;
   logic [7:0]         spd_lo_q, spd_lo_d;
   logic [7:0]         temp_q, temp_d;
`ifdef PACK_CHKSUM_EN
   logic [7:0]         chk_q, chk_d;
`endif

   logic               tick_c;
   logic               hs_c;
   logic [6:0]         duty_c;
   logic [IDX_W-1:0]   nxt_idx_c;
   logic [7:0]         nxt_byte_c;

   assign tick_c    = (timer_q == TMR_W'(PERIOD_CYC - 1));
   assign hs_c      = tx_valid_q & tx_if.tx_ready;
   assign duty_c    = (duty_data > 7'd100) ? 7'd100 : duty_data;
   assign nxt_idx_c = IDX_W'(idx_q + IDX_W'(1));

   // Byte that follows the current one, taken from the snapshot registers.
   always_comb begin
      nxt_byte_c = 8'h00;
      case (nxt_idx_c)
         IDX_W'(0): nxt_byte_c = HEAD_BYTE;
         IDX_W'(1): nxt_byte_c = b1_q;
         IDX_W'(2): nxt_byte_c = {4'b0000, spd_hi_q};
         IDX_W'(3): nxt_byte_c = spd_lo_q;
         IDX_W'(4): nxt_byte_c = temp_q;
`ifdef PACK_CHKSUM_EN
         IDX_W'(5): nxt_byte_c = chk_q;
         IDX_W'(6): nxt_byte_c = TAIL_BYTE;
`else
         IDX_W'(5): nxt_byte_c = TAIL_BYTE;
`endif
         default:   nxt_byte_c = 8'h00;
      endcase
   end

   // Next-state, timer and output logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      b1_d       = b1_q;
      spd_hi_d   = spd_hi_q;
      spd_lo_d   = spd_lo_q;
      temp_d     = temp_q;
`ifdef PACK_CHKSUM_EN
      chk_d      = chk_q;
`endif
      // Free-running period timer; keeps counting while a frame is in flight.
      timer_d    = tick_c ? '0 : TMR_W'(timer_q + TMR_W'(1));

      case (state_q)
         IDLE: begin
            // Tick and request in the same cycle still give a single frame.
            if (tick_c || report_req) begin
               state_d = LOAD;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            b1_d       = {mode, duty_c};
            spd_hi_d   = speed_data[11:8];
            spd_lo_d   = speed_data[7:0];
            temp_d     = temp_data;
`ifdef PACK_CHKSUM_EN
            chk_d      = 8'({mode, duty_c} + {4'b0000, speed_data[11:8]}
                            + speed_data[7:0] + temp_data);
`endif
            idx_d      = '0;
            tx_data_d  = HEAD_BYTE;
            tx_valid_d = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            if (hs_c) begin
               if (idx_q == LAST_IDX) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  idx_d      = '0;
                  state_d    = IDLE;
               end else begin
                  idx_d     = nxt_idx_c;
                  tx_data_d = nxt_byte_c;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         b1_q       <= 8'h00;
         spd_hi_q   <= 4'h0;
         spd_lo_q   <= 8'h00;
         temp_q     <= 8'h00;
`ifdef PACK_CHKSUM_EN
         chk_q      <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         b1_q       <= b1_d;
         spd_hi_q   <= spd_hi_d;
         spd_lo_q   <= spd_lo_d;
         temp_q     <= temp_d;
`ifdef PACK_CHKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

   assign tx_if.tx_data  = tx_data_q;
   assign tx_if.tx_valid = tx_valid_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_status_pack_tx.sv
// Directed bench for status_pack_tx with PERIOD_CYC = 100.
module tb_status_pack_tx;
   localparam int unsigned P = 100;
`ifdef PACK_CHKSUM_EN
   localparam int NB = 7;
`else
   localparam int NB = 6;
`endif

   typedef logic [7:0] frame_t [7];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode;
   logic [6:0]  duty;
   logic [11:0] speed;
   logic [7:0]  temp;
   logic        req;
   logic        busy;
   int          errors = 0;
   int          checks = 0;
   int          cyc;
   frame_t      f1, f3;

   always #5 clk = ~clk;

   // Clock edges since reset release; cyc % P mirrors the period timer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   status_pack_tx_if tx_if ();

   status_pack_tx #(.PERIOD_CYC(P), .HEAD_BYTE(8'hAA), .TAIL_BYTE(8'h55)) dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .mode       (mode),
      .duty_data  (duty),
      .speed_data (speed),
      .temp_data  (temp),
      .report_req (req),
      .tx_if      (tx_if.master),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic no_valid(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx_if.tx_valid) seen++;
      end
      chk(tag, seen, 0);
   endtask

   task automatic wait_mod(input string tag, input int m);
      int g = 0;
      while ((cyc % P) != m && g < 250) begin
         @(negedge clk);
         g++;
      end
      chk({tag, " reached"}, ((cyc % P) == m) ? 1 : 0, 1);
   endtask

   // Receive one frame; optionally stall on one byte, pulse report_req, or change inputs.
   task automatic recv_frame(input string tag, input frame_t exp, input int req_idx,
                             input int stall_idx, input int stall_len, input int chg_idx);
      int got = 0;
      int guard = 0;
      while (!tx_if.tx_valid && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " start"}, tx_if.tx_valid, 1);
      while (got < NB && guard < 600) begin
         if (tx_if.tx_valid) begin
            if (got == stall_idx) begin
               tx_if.tx_ready = 1'b0;
               for (int s = 0; s < stall_len; s++) begin
                  @(negedge clk);
                  guard++;
                  chk($sformatf("%s stall%0d valid", tag, s), tx_if.tx_valid, 1);
                  chk($sformatf("%s stall%0d data", tag, s), tx_if.tx_data, exp[got]);
               end
               tx_if.tx_ready = 1'b1;
            end
            chk($sformatf("%s byte%0d", tag, got), tx_if.tx_data, exp[got]);
            chk($sformatf("%s busy%0d", tag, got), busy, 1);
            if (got == req_idx) req = 1'b1;
            if (got == chg_idx) begin
               mode = 1'b0; duty = 7'd120; speed = 12'd500; temp = 8'd45;
            end
            got++;
         end
         @(negedge clk);
         guard++;
         req = 1'b0;
      end
      chk({tag, " count"}, got, NB);
      chk({tag, " valid end"}, tx_if.tx_valid, 0);
      chk({tag, " busy end"}, busy, 0);
   endtask

   initial begin
`ifdef PACK_CHKSUM_EN
      f1 = '{8'hAA, 8'hB2, 8'h07, 8'h9E, 8'h1C, 8'h73, 8'h55};
      f3 = '{8'hAA, 8'h64, 8'h01, 8'hF4, 8'h2D, 8'h86, 8'h55};
`else
      f1 = '{8'hAA, 8'hB2, 8'h07, 8'h9E, 8'h1C, 8'h55, 8'h00};
      f3 = '{8'hAA, 8'h64, 8'h01, 8'hF4, 8'h2D, 8'h55, 8'h00};
`endif
      mode = 1'b1; duty = 7'd50; speed = 12'd1950; temp = 8'd28;
      req = 1'b0;
      tx_if.tx_ready = 1'b1;
      rst_n = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset data", tx_if.tx_data, 8'h00);
      chk("reset valid", tx_if.tx_valid, 0);
      chk("reset busy", busy, 0);

      // First automatic frame: tick after edge 99, LOAD after 100, valid after 101
      rst_n = 1'b1;
      no_valid("pre-tick idle", 99);
      chk("tick cycle busy", busy, 0);
      @(negedge clk);
      chk("load valid", tx_if.tx_valid, 0);
      chk("load busy", busy, 1);
      @(negedge clk);
      chk("tick latency valid", tx_if.tx_valid, 1);
      recv_frame("t1", f1, -1, -1, 0, -1);

      // Next tick: stall 3 cycles on byte 2; inputs change mid-frame (snapshot must hold)
      recv_frame("t2", f1, -1, 2, 3, 1);

      // report_req from IDLE, plus a second request while sending (must be ignored)
      wait_mod("t3", 10);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("t3 load valid", tx_if.tx_valid, 0);
      chk("t3 load busy", busy, 1);
      @(negedge clk);
      chk("t3 req latency", tx_if.tx_valid, 1);
      recv_frame("t3", f3, 1, -1, 0, -1);
      no_valid("t3 no extra frame", 30);

      // report_req coinciding with the tick: exactly one frame
      wait_mod("t4", 99);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("t4 load busy", busy, 1);
      @(negedge clk);
      chk("t4 latency", tx_if.tx_valid, 1);
      recv_frame("t4", f3, -1, -1, 0, -1);
      no_valid("t4 no extra frame", 40);

      // Reset while byte 3 is presented
      wait_mod("t5", 1);
      chk("t5 valid", tx_if.tx_valid, 1);
      chk("t5 head", tx_if.tx_data, 8'hAA);
      repeat (3) @(negedge clk);
      chk("t5 byte3", tx_if.tx_data, f3[3]);
      #1 rst_n = 1'b0;
      #1;
      chk("t5 async valid", tx_if.tx_valid, 0);
      chk("t5 async busy", busy, 0);
      chk("t5 async data", tx_if.tx_data, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      no_valid("t5 quiet after release", 100);
      @(negedge clk);
      chk("t5 first frame after release", tx_if.tx_valid, 1);
      recv_frame("t5 post", f3, -1, -1, 0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
